hazard_sched: RTL and testbench

- Pipeline hazard scheduler for the 5-stage MIPS core.
- Keeps its own E/M/W shadow copies of each in-flight instruction's write address and remaining-latency (Tnew) count.
- Compares them against the D-stage source registers and their Tuse to drive the D-stage stall, the D/E bubble, and the D-stage forwarding selects.
- Also sequences the multiply/divide unit with a busy counter, so HI/LO consumers stall until the result is ready.

---
 rtl/hazard_sched_if.sv | 31 +++
 rtl/hazard_sched.sv | 110 +++++++++++
 tb/tb_hazard_sched.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sched_if.sv
// rtl/hazard_sched_if.sv - D-stage hazard request/response bundle for hazard_sched.
// The pipeline (master) drives the D-stage descriptor; the scheduler (slave) returns stall/forward controls.
interface hazard_sched_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [1:0] tuseRsD;
  logic [1:0] tuseRtD;
  logic [4:0] waD;
  logic [1:0] tnewD;
  logic       mdStartD;
  logic       mdDivD;
  logic       mdUseD;
  logic       excFlush;
  logic       stallD;
  logic       clrE;
  logic [1:0] fwdRsD;
  logic [1:0] fwdRtD;
  logic       mdBusy;

  modport master (
    output rsD, rtD, tuseRsD, tuseRtD, waD, tnewD,
    output mdStartD, mdDivD, mdUseD, excFlush,
    input  stallD, clrE, fwdRsD, fwdRtD, mdBusy
  );

  modport slave (
    input  rsD, rtD, tuseRsD, tuseRtD, waD, tnewD,
    input  mdStartD, mdDivD, mdUseD, excFlush,
    output stallD, clrE, fwdRsD, fwdRtD, mdBusy
  );
endinterface

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - Tuse/Tnew hazard scheduler: D-stage stall, D/E bubble, forwarding selects, mult/div busy.
// Shadows the write address and remaining latency of the E/M/W instructions.
module hazard_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic           clk,
  input  logic           rst,
  hazard_sched_if.slave  hs
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  logic [4:0] wa_e, wa_m, wa_w;
  logic [1:0] tn_e, tn_m;
  logic [3:0] md_cnt;

  logic       stall_rs, stall_rt, stall_md, stall_d, md_busy;
  logic [1:0] fwd_rs, fwd_rt;
  logic [1:0] tn_dcl;

  // A source stalls only if a producer still needs more cycles than the consumer can wait.
  function automatic logic src_stall(
    input logic [4:0] s,
    input logic [1:0] tuse,
    input logic [4:0] we,
    input logic [1:0] te,
    input logic [4:0] wm,
    input logic [1:0] tm
  );
    logic live;
    live = (s != 5'd0) && (tuse != 2'd3);
    return live && (((we == s) && (te > tuse)) || ((wm == s) && (tm > tuse)));
  endfunction

  // Youngest matching stage wins; a not-yet-ready match hides older copies.
  function automatic logic [1:0] src_fwd(
    input logic [4:0] s,
    input logic [4:0] we,
    input logic [1:0] te,
    input logic [4:0] wm,
    input logic [1:0] tm,
    input logic [4:0] ww
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (s == 5'd0)
      sel = 2'd0;
    else if (we == s)
      sel = (te == 2'd0) ? 2'd1 : 2'd0;
    else if (wm == s)
      sel = (tm == 2'd0) ? 2'd2 : 2'd0;
    else if (ww == s)
      sel = 2'd3;
    return sel;
  endfunction

  always_comb begin
    md_busy  = (md_cnt != 4'd0);
    stall_md = hs.mdUseD && md_busy;
    stall_rs = src_stall(hs.rsD, hs.tuseRsD, wa_e, tn_e, wa_m, tn_m);
    stall_rt = src_stall(hs.rtD, hs.tuseRtD, wa_e, tn_e, wa_m, tn_m);
    stall_d  = stall_rs | stall_rt | stall_md;
    fwd_rs   = src_fwd(hs.rsD, wa_e, tn_e, wa_m, tn_m, wa_w);
    fwd_rt   = src_fwd(hs.rtD, wa_e, tn_e, wa_m, tn_m, wa_w);
    tn_dcl   = (hs.waD == 5'd0) ? 2'd0 : hs.tnewD;
  end

  assign hs.stallD = stall_d;
  assign hs.clrE   = stall_d;
  assign hs.fwdRsD = fwd_rs;
  assign hs.fwdRtD = fwd_rt;
  assign hs.mdBusy = md_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa_e   <= 5'd0;
      wa_m   <= 5'd0;
      wa_w   <= 5'd0;
      tn_e   <= 2'd0;
      tn_m   <= 2'd0;
      md_cnt <= 4'd0;
    end else if (hs.excFlush) begin
      wa_e   <= 5'd0;
      wa_m   <= 5'd0;
      wa_w   <= 5'd0;
      tn_e   <= 2'd0;
      tn_m   <= 2'd0;
      md_cnt <= 4'd0;
    end else begin
      wa_w <= wa_m;
      wa_m <= wa_e;
      tn_m <= (tn_e == 2'd0) ? 2'd0 : tn_e - 2'd1;
      if (stall_d) begin
        wa_e <= 5'd0;
        tn_e <= 2'd0;
      end else begin
        wa_e <= hs.waD;
        tn_e <= tn_dcl;
      end
      // A start is only accepted when not stalled, which implies the unit is idle.
      if (hs.mdStartD && !stall_d)
        md_cnt <= hs.mdDivD ? DIV_LOAD : MULT_LOAD;
      else if (md_cnt != 4'd0)
        md_cnt <= md_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - Directed vector table plus multi-cycle sequences for hazard_sched.
module tb_hazard_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_sched_if hs();

  hazard_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk (clk),
    .rst (rst),
    .hs  (hs)
  );

  // Slot 0 is pushed first and ends in W, slot 1 in M (tn drops by one), slot 2 in E.
  typedef struct {
    string      name;
    logic [4:0] wa0, wa1, wa2;
    logic [1:0] tn0, tn1, tn2;
    logic [4:0] rs;
    logic [1:0] tur;
    logic [4:0] rt;
    logic [1:0] tut;
    logic       stall;
    logic [1:0] frs;
    logic [1:0] frt;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    hs.rsD = 5'd0;      hs.rtD = 5'd0;
    hs.tuseRsD = 2'd3;  hs.tuseRtD = 2'd3;
    hs.waD = 5'd0;      hs.tnewD = 2'd0;
    hs.mdStartD = 1'b0; hs.mdDivD = 1'b0; hs.mdUseD = 1'b0;
    hs.excFlush = 1'b0;
  endtask

  task automatic do_flush();
    set_idle();
    hs.excFlush = 1'b1;
    step();
    hs.excFlush = 1'b0;
  endtask

  task automatic push(input logic [4:0] wa, input logic [1:0] tn);
    set_idle();
    hs.waD = wa;
    hs.tnewD = tn;
    step();
  endtask

  int cnt;
  int stall_bad;

  initial begin
    vecs[0]  = '{"ld_e_tuse1",   5'd0, 5'd0, 5'd8,  2'd0, 2'd0, 2'd2, 5'd8,  2'd1, 5'd0,  2'd3, 1'b1, 2'd0, 2'd0};
    vecs[1]  = '{"ld_e_tuse2",   5'd0, 5'd0, 5'd8,  2'd0, 2'd0, 2'd2, 5'd8,  2'd2, 5'd0,  2'd3, 1'b0, 2'd0, 2'd0};
    vecs[2]  = '{"ld_m_tuse0",   5'd0, 5'd8, 5'd0,  2'd0, 2'd2, 2'd0, 5'd8,  2'd0, 5'd0,  2'd3, 1'b1, 2'd0, 2'd0};
    vecs[3]  = '{"ld_m_tuse1",   5'd0, 5'd8, 5'd0,  2'd0, 2'd2, 2'd0, 5'd8,  2'd1, 5'd0,  2'd3, 1'b0, 2'd0, 2'd0};
    vecs[4]  = '{"alu_e_tuse1",  5'd0, 5'd0, 5'd3,  2'd0, 2'd0, 2'd1, 5'd3,  2'd1, 5'd0,  2'd3, 1'b0, 2'd0, 2'd0};
    vecs[5]  = '{"alu_e_tuse0",  5'd0, 5'd0, 5'd5,  2'd0, 2'd0, 2'd1, 5'd5,  2'd0, 5'd0,  2'd3, 1'b1, 2'd0, 2'd0};
    vecs[6]  = '{"alu_m_fwd",    5'd0, 5'd3, 5'd0,  2'd0, 2'd1, 2'd0, 5'd3,  2'd0, 5'd0,  2'd3, 1'b0, 2'd2, 2'd0};
    vecs[7]  = '{"w_only_fwd",   5'd5, 5'd0, 5'd0,  2'd1, 2'd0, 2'd0, 5'd5,  2'd0, 5'd0,  2'd3, 1'b0, 2'd3, 2'd0};
    vecs[8]  = '{"prio_e",       5'd9, 5'd9, 5'd9,  2'd0, 2'd0, 2'd0, 5'd0,  2'd3, 5'd9,  2'd0, 1'b0, 2'd0, 2'd1};
    vecs[9]  = '{"rt_zero",      5'd9, 5'd9, 5'd9,  2'd0, 2'd0, 2'd0, 5'd0,  2'd3, 5'd0,  2'd0, 1'b0, 2'd0, 2'd0};
    vecs[10] = '{"not_read",     5'd0, 5'd0, 5'd8,  2'd0, 2'd0, 2'd2, 5'd8,  2'd3, 5'd0,  2'd3, 1'b0, 2'd0, 2'd0};
    vecs[11] = '{"e_blocks_m",   5'd0, 5'd7, 5'd7,  2'd0, 2'd1, 2'd2, 5'd7,  2'd2, 5'd0,  2'd3, 1'b0, 2'd0, 2'd0};
    vecs[12] = '{"rs_rt_mix",    5'd0, 5'd4, 5'd6,  2'd0, 2'd1, 2'd1, 5'd4,  2'd0, 5'd6,  2'd1, 1'b0, 2'd2, 2'd0};
    vecs[13] = '{"rt_load",      5'd0, 5'd0, 5'd10, 2'd0, 2'd0, 2'd2, 5'd0,  2'd3, 5'd10, 2'd1, 1'b1, 2'd0, 2'd0};
    vecs[14] = '{"wad_zero_e",   5'd0, 5'd7, 5'd0,  2'd0, 2'd1, 2'd2, 5'd7,  2'd0, 5'd0,  2'd3, 1'b0, 2'd2, 2'd0};
    vecs[15] = '{"m_blocks_w",   5'd5, 5'd5, 5'd0,  2'd1, 2'd2, 2'd0, 5'd5,  2'd2, 5'd0,  2'd3, 1'b0, 2'd0, 2'd0};

    set_idle();
    hs.mdUseD = 1'b1;
    hs.rsD = 5'd1;
    hs.tuseRsD = 2'd0;
    #12;
    chk("rst_stall", hs.stallD, 0);
    chk("rst_clr", hs.clrE, 0);
    chk("rst_fwd", hs.fwdRsD, 0);
    chk("rst_busy", hs.mdBusy, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      do_flush();
      push(vecs[i].wa0, vecs[i].tn0);
      push(vecs[i].wa1, vecs[i].tn1);
      push(vecs[i].wa2, vecs[i].tn2);
      set_idle();
      hs.rsD = vecs[i].rs;   hs.tuseRsD = vecs[i].tur;
      hs.rtD = vecs[i].rt;   hs.tuseRtD = vecs[i].tut;
      #1;
      chk({vecs[i].name, "_stall"}, hs.stallD, vecs[i].stall);
      chk({vecs[i].name, "_clr"}, hs.clrE, vecs[i].stall);
      chk({vecs[i].name, "_fwdrs"}, hs.fwdRsD, vecs[i].frs);
      chk({vecs[i].name, "_fwdrt"}, hs.fwdRtD, vecs[i].frt);
    end

    // Load-use: exactly one stall cycle, M copy not ready yet, then W forward.
    do_flush();
    push(5'd8, 2'd2);
    set_idle();
    hs.rsD = 5'd8; hs.tuseRsD = 2'd1;
    #1;
    chk("lu_stall_c0", hs.stallD, 1);
    chk("lu_clr_c0", hs.clrE, 1);
    step();
    chk("lu_stall_c1", hs.stallD, 0);
    chk("lu_fwd_c1", hs.fwdRsD, 0);
    step();
    chk("lu_fwd_c2", hs.fwdRsD, 3);

    // ALU result forwarded from M one cycle later.
    do_flush();
    push(5'd3, 2'd1);
    set_idle();
    hs.rsD = 5'd3; hs.tuseRsD = 2'd1;
    #1;
    chk("alu_stall", hs.stallD, 0);
    step();
    chk("alu_fwd_m", hs.fwdRsD, 2);

    // Branch after ALU: one stall, then M, then W.
    do_flush();
    push(5'd5, 2'd1);
    set_idle();
    hs.rsD = 5'd5; hs.tuseRsD = 2'd0;
    #1;
    chk("br_stall_c0", hs.stallD, 1);
    step();
    chk("br_stall_c1", hs.stallD, 0);
    chk("br_fwd_m", hs.fwdRsD, 2);
    step();
    chk("br_fwd_w", hs.fwdRsD, 3);

    // Divide then multiply busy windows.
    for (int k = 0; k < 2; k++) begin
      do_flush();
      hs.mdStartD = 1'b1; hs.mdDivD = (k == 0); hs.mdUseD = 1'b1;
      #1;
      chk("md_issue_stall", hs.stallD, 0);
      chk("md_issue_busy", hs.mdBusy, 0);
      step();
      hs.mdStartD = 1'b0;
      #1;
      cnt = 0;
      stall_bad = 0;
      for (int i = 0; i < 30; i++) begin
        if (!hs.mdBusy) break;
        cnt++;
        if (!hs.stallD) stall_bad = 1;
        step();
      end
      chk(k == 0 ? "div_cycles" : "mult_cycles", cnt, k == 0 ? 10 : 5);
      chk("md_stall_held", stall_bad, 0);
      chk("md_stall_after", hs.stallD, 0);
    end

    // Flush during a stalled divide clears every shadow copy.
    do_flush();
    hs.waD = 5'd4; hs.tnewD = 2'd2;
    hs.mdStartD = 1'b1; hs.mdDivD = 1'b1; hs.mdUseD = 1'b1;
    step();
    hs.waD = 5'd0; hs.tnewD = 2'd0; hs.mdStartD = 1'b0;
    hs.rsD = 5'd4; hs.tuseRsD = 2'd0;
    #1;
    chk("fl_pre_stall", hs.stallD, 1);
    chk("fl_pre_busy", hs.mdBusy, 1);
    hs.excFlush = 1'b1;
    step();
    hs.excFlush = 1'b0;
    #1;
    chk("fl_stall", hs.stallD, 0);
    chk("fl_busy", hs.mdBusy, 0);
    chk("fl_fwd", hs.fwdRsD, 0);
    step();
    chk("fl_fwd_w", hs.fwdRsD, 0);

    // Asynchronous reset mid-multiply.
    do_flush();
    hs.waD = 5'd4; hs.tnewD = 2'd2;
    hs.mdStartD = 1'b1; hs.mdDivD = 1'b0; hs.mdUseD = 1'b1;
    step();
    hs.waD = 5'd0; hs.tnewD = 2'd0; hs.mdStartD = 1'b0;
    hs.rsD = 5'd4; hs.tuseRsD = 2'd0;
    #1;
    chk("ar_pre_stall", hs.stallD, 1);
    chk("ar_pre_busy", hs.mdBusy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_stall", hs.stallD, 0);
    chk("ar_clr", hs.clrE, 0);
    chk("ar_busy", hs.mdBusy, 0);
    chk("ar_fwd", hs.fwdRsD, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("ar_post_stall", hs.stallD, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
